riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RISC-V (RV32I subset) datapath.
- Sequences one shared ALU, one unified memory port and the register file across fetch, decode, execute, memory and writeback cycles.
- Drives alu_op into the existing ALU decoder: 00 = add, 01 = branch compare, 10 = funct-decoded.
- Resolves branch-taken from the ALU zero flag and funct3.
- Stalls on a ready handshake from memory.

Parameters:
STALL_CNT_W, 16, width of the saturating memory-stall performance counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instruction opcode (from IR)
funct3  in  3  instruction funct3 (from IR)
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  write strobe; qualifies mem_req
adr_src  out  1  address source: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from result bus
reg_write  out  1  register file write enable
result_src  out  2  result bus: 00 = ALUOut, 01 = read data, 10 = ALUResult
alu_src_a  out  2  ALU A: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
alu_src_b  out  2  ALU B: 00 = RD2, 01 = ImmExt, 10 = constant 4
alu_op  out  2  to ALU decoder
imm_src  out  3  immediate type: I = 000, S = 001, B = 010, J = 011, U = 100
state  out  4  current state, for debug
stall_cycles  out  STALL_CNT_W  memory-wait cycle counter
illegal  out  1  illegal instruction flag (see Optional Feature)

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = FETCH (0); stall_cycles = 0; illegal = 0.
  - All strobes (mem_req, mem_write, ir_write, pc_write, reg_write) forced to 0; all mux selects 0.
  - Reset may hit any state, including mid memory wait. After release the first cycle is FETCH; no write strobe survives the reset.
- Outputs are combinational from state (plus op, funct3, zero, mem_ready where noted). Unlisted outputs are 0.
- imm_src is a pure function of op in every state: lw/addi/jalr = I, sw = S, branch = B, jal = J, lui/auipc = U.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, UPPER 12, TRAP 13.
- FETCH:
  - mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, next state DECODE.
  - When mem_ready = 0: hold FETCH with ir_write = pc_write = 0.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch/jal target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 or 0010111 → UPPER
  - anything else → illegal handling
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next state MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1. When mem_ready = 1 → MEMWB; otherwise hold.
- MEMWB: result_src = 01, reg_write = 1. Next state FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. When mem_ready = 1 → FETCH; otherwise hold.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next state ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10. Next state ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Next state FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00; pc_write = taken. Next state FETCH.
  - funct3 000 (beq): taken = zero.
  - funct3 001 (bne), 100 (blt), 110 (bltu): taken = !zero.
  - funct3 101 (bge), 111 (bgeu): taken = zero.
  - funct3 010 and 011 are illegal and are detected in DECODE.
- JALR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next state JAL.
- JAL: result_src = 00, pc_write = 1, alu_src_a = 01, alu_src_b = 10, alu_op = 00 (link = OldPC + 4). Next state ALUWB.
- UPPER: alu_src_a = 11 for lui, 01 for auipc; alu_src_b = 01, alu_op = 00. Next state ALUWB.
- stall_cycles: increments by 1 every cycle mem_req = 1 and mem_ready = 0; saturates at all-ones; never wraps.
- Fetch-to-fetch latency with mem_ready held at 1:
  - R/I-type, lui, auipc: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch: 3 cycles.
  - jal: 4 cycles.
  - jalr: 5 cycles.
  - Each cycle of mem_ready = 0 adds one cycle.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal op, or a branch with funct3 01x, moves DECODE → TRAP. In TRAP, illegal = 1 and all strobes are 0; the FSM stays in TRAP until reset.
- Undefined: illegal decode moves DECODE → FETCH and executes as a NOP (PC already advanced in FETCH). illegal is tied to 0 and TRAP is unreachable.

Test Plan:
- Reset release, add (op 0110011), mem_ready = 1 → state sequence 0, 1, 6, 8, 0; alu_op = 10 only in EXECR; reg_write = 1 only in ALUWB.
- lw with mem_ready low for 3 cycles in MEMREAD → MEMREAD held 3 extra cycles; stall_cycles rises by 3; MEMWB asserts reg_write = 1 with result_src = 01.
- Branch compares:
  - bne, zero = 0 → pc_write = 1 in BRANCH.
  - bne, zero = 1 → pc_write = 0.
  - bge (funct3 101), zero = 0 → pc_write = 0.
  - bltu (funct3 110), zero = 0 → pc_write = 1.
- jalr → sequence 1, 11, 10, 8; pc_write = 1 with result_src = 00 only in JAL; reg_write = 1 in ALUWB.
- rst_n dropped while held in MEMWRITE (mem_ready = 0) → mem_write and mem_req go to 0 immediately; after release state = 0 and stall_cycles = 0.
- op 1111111:
  - ILLEGAL_TRAP_EN defined → state 13, illegal = 1, held for 10 cycles.
  - ILLEGAL_TRAP_EN undefined → state 0 the cycle after DECODE, illegal = 0.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// ============================================================================
// Module   : riscv_multicycle_ctrl
// Brief    : Main control FSM for a multicycle RV32I datapath. Optional
//            ILLEGAL_TRAP_EN macro parks illegal decodes in a sticky TRAP state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module riscv_multicycle_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             op_i,
    input  logic [2:0]             funct3_i,
    input  logic                   zero_i,
    input  logic                   mem_ready_i,
    output logic                   mem_req_o,
    output logic                   mem_write_o,
    output logic                   adr_src_o,
    output logic                   ir_write_o,
    output logic                   pc_write_o,
    output logic                   reg_write_o,
    output logic [1:0]             result_src_o,
    output logic [1:0]             alu_src_a_o,
    output logic [1:0]             alu_src_b_o,
    output logic [1:0]             alu_op_o,
    output logic [2:0]             imm_src_o,
    output logic [3:0]             state_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o,
    output logic                   illegal_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_q;

    logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op;
    logic       w_taken;

`ifdef ILLEGAL_TRAP_EN
    localparam state_e S_ILLEGAL_NEXT = S_TRAP;
`else
    localparam state_e S_ILLEGAL_NEXT = S_FETCH;
`endif

    // beq/bge/bgeu take on zero; bne/blt/bltu take on non-zero.
    always_comb begin
        w_taken = ~zero_i;
        case (funct3_i)
            3'b000, 3'b101, 3'b111: w_taken = zero_i;
            default:                w_taken = ~zero_i;
        endcase
    end

    always_comb begin
        imm_src_o = 3'b000;
        case (op_i)
            OP_STORE:          imm_src_o = 3'b001;
            OP_BRANCH:         imm_src_o = 3'b010;
            OP_JAL:            imm_src_o = 3'b011;
            OP_LUI, OP_AUIPC:  imm_src_o = 3'b100;
            default:           imm_src_o = 3'b000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (mem_ready_i) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = (funct3_i[2:1] == 2'b01) ? S_ILLEGAL_NEXT : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                state_d     = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_pc_write  = w_taken;
                state_d     = S_FETCH;
            end
            S_JALR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                state_d     = S_JAL;
            end
            S_JAL: begin
                // Target already sits in ALUOut; ALU meanwhile forms the link value.
                w_pc_write  = 1'b1;
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                state_d     = S_ALUWB;
            end
            S_UPPER: begin
                w_alu_src_a = (op_i == OP_LUI) ? 2'b11 : 2'b01;
                w_alu_src_b = 2'b01;
                state_d     = S_ALUWB;
            end
            S_TRAP:  state_d = S_ILLEGAL_NEXT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes and selects are held low for as long as reset is asserted.
    always_comb begin
        mem_req_o    = rst_n & w_mem_req;
        mem_write_o  = rst_n & w_mem_write;
        adr_src_o    = rst_n & w_adr_src;
        ir_write_o   = rst_n & w_ir_write;
        pc_write_o   = rst_n & w_pc_write;
        reg_write_o  = rst_n & w_reg_write;
        result_src_o = rst_n ? w_result_src : 2'b00;
        alu_src_a_o  = rst_n ? w_alu_src_a  : 2'b00;
        alu_src_b_o  = rst_n ? w_alu_src_b  : 2'b00;
        alu_op_o     = rst_n ? w_alu_op     : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_mem_req && !mem_ready_i && !(&stall_q))
                stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign state_o        = state_q;
    assign stall_cycles_o = stall_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_o = (state_q == S_TRAP);
`else
    assign illegal_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_riscv_multicycle_ctrl
// Brief    : Self-checking bench for riscv_multicycle_ctrl against an
//            instruction-level reference model (honours ILLEGAL_TRAP_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_multicycle_ctrl;

    localparam int STALL_CNT_W = 16;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] REG    = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [6:0]             op_i;
    logic [2:0]             funct3_i;
    logic                   zero_i;
    logic                   mem_ready_i;
    logic                   mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0]             result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o;
    logic [2:0]             imm_src_o;
    logic [3:0]             state_o;
    logic [STALL_CNT_W-1:0] stall_cycles_o;
    logic                   illegal_o;

    int checks   = 0;
    int failures = 0;
    logic [STALL_CNT_W-1:0] model_stall;

    riscv_multicycle_ctrl #(.STALL_CNT_W(STALL_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .funct3_i(funct3_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
        .adr_src_o(adr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .reg_write_o(reg_write_o), .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .imm_src_o(imm_src_o),
        .state_o(state_o), .stall_cycles_o(stall_cycles_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    wire [17:0] act_ctrl = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                            result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, imm_src_o, illegal_o};

    // Control table per state, written straight from the instruction semantics.
    function automatic logic [17:0] exp_ctrl(input int s, input logic [6:0] o, input logic [2:0] f3,
                                             input logic z, input logic rdy);
        logic mreq = 0, mw = 0, adr = 0, ir = 0, pcw = 0, rw = 0, ill = 0, tk;
        logic [1:0] rs = 0, a = 0, b = 0, aop = 0;
        logic [2:0] imm = 0;
        tk = (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) ? z : !z;
        if (o == STORE) imm = 3'd1;
        else if (o == BRANCH) imm = 3'd2;
        else if (o == JAL) imm = 3'd3;
        else if (o == LUI || o == AUIPC) imm = 3'd4;
        case (s)
            0:  begin mreq = 1; rs = 2; b = 2; ir = rdy; pcw = rdy; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  begin mreq = 1; adr = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin mreq = 1; mw = 1; adr = 1; end
            6:  begin a = 2; aop = 2; end
            7:  begin a = 2; b = 1; aop = 2; end
            8:  rw = 1;
            9:  begin a = 2; aop = 1; pcw = tk; end
            10: begin pcw = 1; a = 1; b = 2; end
            11: begin a = 2; b = 1; end
            12: begin a = (o == LUI) ? 2'd3 : 2'd1; b = 1; end
            13: ill = 1;
            default: ;
        endcase
        return {mreq, mw, adr, ir, pcw, rw, rs, a, b, aop, imm, ill};
    endfunction

    // Runs one instruction from FETCH to its last state; fw/mw = memory wait cycles.
    task automatic drive_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                               input int fw, input int mw);
        int seq[$];
        int memcnt = 0;
        logic rdy;
        for (int i = 0; i <= fw; i++) seq.push_back(0);
        seq.push_back(1);
        case (o)
            REG:         begin seq.push_back(6); seq.push_back(8); end
            OPIMM:       begin seq.push_back(7); seq.push_back(8); end
            LOAD:        begin seq.push_back(2); for (int i = 0; i <= mw; i++) seq.push_back(3); seq.push_back(4); end
            STORE:       begin seq.push_back(2); for (int i = 0; i <= mw; i++) seq.push_back(5); end
            BRANCH:      seq.push_back(9);
            JAL:         begin seq.push_back(10); seq.push_back(8); end
            JALR:        begin seq.push_back(11); seq.push_back(10); seq.push_back(8); end
            LUI, AUIPC:  begin seq.push_back(12); seq.push_back(8); end
            default: ;
        endcase
        for (int k = 0; k < seq.size(); k++) begin
            if (seq[k] == 0) rdy = (k >= fw);
            else if (seq[k] == 3 || seq[k] == 5) begin rdy = (memcnt >= mw); memcnt++; end
            else rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            op_i = o; funct3_i = f3; zero_i = z; mem_ready_i = rdy;
            #2;
            checks++;
            if (state_o !== 4'(seq[k])) begin
                failures++;
                $display("FAIL state op=%b f3=%0d step %0d: got %0d expected %0d", o, f3, k, state_o, seq[k]);
            end
            checks++;
            if (act_ctrl !== exp_ctrl(seq[k], o, f3, z, rdy)) begin
                failures++;
                $display("FAIL ctrl op=%b f3=%0d state %0d: got %b expected %b", o, f3, seq[k], act_ctrl,
                         exp_ctrl(seq[k], o, f3, z, rdy));
            end
            if ((seq[k] == 0 || seq[k] == 3 || seq[k] == 5) && !rdy && model_stall != '1)
                model_stall++;
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cycles_o !== model_stall) begin
            failures++;
            $display("FAIL stall_cycles op=%b: got %0d expected %0d", o, stall_cycles_o, model_stall);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_i = REG; funct3_i = 0; zero_i = 0; mem_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #2;
            checks++;
            if ({state_o, stall_cycles_o, illegal_o} !== '0) begin
                failures++;
                $display("FAIL reset_state: got st=%0d stall=%0d ill=%b expected 0/0/0", state_o, stall_cycles_o, illegal_o);
            end
            checks++;
            if (act_ctrl[17:4] !== 14'd0) begin
                failures++;
                $display("FAIL reset_strobes: got %b expected 0", act_ctrl[17:4]);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1; #1;
        model_stall = '0;
        checks++;
        if (state_o !== 4'd0) begin
            failures++;
            $display("FAIL reset_release: got %0d expected 0", state_o);
        end
    endtask

    task automatic test_add();
        drive_instr(REG, 3'd0, 1'b0, 0, 0);
    endtask

    task automatic test_lw_stall();
        drive_instr(LOAD, 3'd2, 1'b0, 0, 3);
    endtask

    task automatic test_branches();
        drive_instr(BRANCH, 3'b001, 1'b0, 0, 0);
        drive_instr(BRANCH, 3'b001, 1'b1, 0, 0);
        drive_instr(BRANCH, 3'b101, 1'b0, 0, 0);
        drive_instr(BRANCH, 3'b110, 1'b0, 1, 0);
        drive_instr(BRANCH, 3'b000, 1'b1, 0, 0);
    endtask

    task automatic test_jalr();
        drive_instr(JALR, 3'd0, 1'b0, 0, 0);
        drive_instr(JAL, 3'd0, 1'b1, 2, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [9] = '{REG, OPIMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC};
        logic [2:0] bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [6:0] o;
        logic [2:0] f;
        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(0, 8)];
            f = (o == BRANCH) ? bf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            drive_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_midwrite();
        int   st [5] = '{0, 1, 2, 5, 5};
        logic rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            op_i = STORE; funct3_i = 3'd2; zero_i = 0; mem_ready_i = rd[k];
            #2;
            checks++;
            if (state_o !== 4'(st[k])) begin
                failures++;
                $display("FAIL midwrite_seq step %0d: got %0d expected %0d", k, state_o, st[k]);
            end
        end
        checks++;
        if ({mem_req_o, mem_write_o} !== 2'b11) begin
            failures++;
            $display("FAIL midwrite_strobe: got %b expected 11", {mem_req_o, mem_write_o});
        end
        #1 rst_n = 1'b0; #1;
        model_stall = '0;
        checks++;
        if ({mem_req_o, mem_write_o, state_o, stall_cycles_o} !== '0) begin
            failures++;
            $display("FAIL midwrite_reset: got req=%b wr=%b st=%0d stall=%0d expected all 0",
                     mem_req_o, mem_write_o, state_o, stall_cycles_o);
        end
        @(posedge clk); #1 rst_n = 1'b1; #1;
        checks++;
        if ({state_o, stall_cycles_o, mem_write_o} !== '0) begin
            failures++;
            $display("FAIL midwrite_release: got st=%0d stall=%0d wr=%b expected 0", state_o, stall_cycles_o, mem_write_o);
        end
        drive_instr(STORE, 3'd2, 1'b0, 0, 1);
    endtask

    task automatic test_illegal();
        logic [6:0] iop [2] = '{7'b1111111, BRANCH};
        logic [2:0] if3 [2] = '{3'd0, 3'd3};
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                op_i = iop[t]; funct3_i = if3[t]; zero_i = 0; mem_ready_i = 1'b1;
                #2;
                checks++;
                if (state_o !== 4'(k) || illegal_o !== 1'b0) begin
                    failures++;
                    $display("FAIL illegal_pre step %0d: got st=%0d ill=%b expected st=%0d ill=0", k, state_o, illegal_o, k);
                end
            end
`ifdef ILLEGAL_TRAP_EN
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                mem_ready_i = 1'($urandom_range(0, 1));
                #2;
                checks++;
                if (state_o !== 4'd13 || act_ctrl !== exp_ctrl(13, iop[t], if3[t], 1'b0, mem_ready_i)) begin
                    failures++;
                    $display("FAIL trap_hold cycle %0d: got st=%0d ctrl=%b expected st=13 ctrl=%b", c, state_o,
                             act_ctrl, exp_ctrl(13, iop[t], if3[t], 1'b0, mem_ready_i));
                end
            end
            checks++;
            if (stall_cycles_o !== model_stall) begin
                failures++;
                $display("FAIL trap_stall: got %0d expected %0d", stall_cycles_o, model_stall);
            end
            @(negedge clk); #2 rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1; #1;
            model_stall = '0;
            checks++;
            if (state_o !== 4'd0 || illegal_o !== 1'b0) begin
                failures++;
                $display("FAIL trap_exit: got st=%0d ill=%b expected 0/0", state_o, illegal_o);
            end
`else
            @(negedge clk);
            mem_ready_i = 1'b0;
            #2;
            checks++;
            if (state_o !== 4'd0 || illegal_o !== 1'b0) begin
                failures++;
                $display("FAIL illegal_nop: got st=%0d ill=%b expected 0/0", state_o, illegal_o);
            end
            if (model_stall != '1) model_stall++;
`endif
            drive_instr(OPIMM, 3'd0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        model_stall = '0;
        test_reset();
        test_add();
        test_lw_stall();
        test_branches();
        test_jalr();
        test_random();
        test_reset_midwrite();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
